// File: rtl/pipe_rot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_rot_pkg
// Purpose  : Shared constants and the rotate-right helper used by every
//            stage of pipe_right_rotator.
// Contents : c_n / c_w      - default log2 width and derived data width
//            c_n_max/c_w_max - widest configuration the helper supports
//            rotate_right()  - rotate a word of 'width' bits right by 'amount'
// Revision : 1.0 - initial release
// ============================================================================
package pipe_rot_pkg;

    localparam int unsigned c_n     = 4;
    localparam int unsigned c_w     = 2 ** c_n;
    localparam int unsigned c_n_max = 6;
    localparam int unsigned c_w_max = 2 ** c_n_max;

    // 'data' must be zero above bit width-1. The left-shifted copy supplies
    // the wrapped-around low bits; the mask drops whatever it pushes past
    // the top of the word.
    function automatic logic [c_w_max-1:0] rotate_right(
        input logic [c_w_max-1:0] data,
        input int unsigned        width,
        input int unsigned        amount
    );
        logic [c_w_max-1:0] mask;
        mask = (width >= c_w_max) ? '1
                                  : ((c_w_max'(1) << width) - c_w_max'(1));
        return ((data >> amount) | (data << (width - amount))) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rot_stage.sv
`default_nettype none
// ============================================================================
// Module   : rot_stage
// Purpose  : One register stage of the rotator pipeline. Rotates the incoming
//            word right by 2**STAGE when amount bit STAGE is set, and carries
//            the remaining amount bits forward with this stage's bit cleared.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            up_valid/up_ready/up_data/up_amt - word arriving from upstream
//            down_valid/down_ready/down_data/down_amt - word held by stage
// Revision : 1.0 - initial release
// ============================================================================
module rot_stage
    import pipe_rot_pkg::*;
#(
    parameter  int unsigned N     = c_n,
    parameter  int unsigned STAGE = 0,
    localparam int unsigned W     = 2 ** N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    input  logic [N-1:0] up_amt,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [W-1:0] down_data,
    output logic [N-1:0] down_amt
);

    localparam logic [N-1:0] c_stage_bit = N'(1) << STAGE;

    logic               r_valid;
    logic [W-1:0]       r_data;
    logic [N-1:0]       r_amt;
    logic               w_load;
    logic [c_w_max-1:0] w_rot_ext;
    logic [W-1:0]       w_next_data;

    // The stage can take a new word when it is empty or its word is leaving.
    assign w_load   = !r_valid || down_ready;
    assign up_ready = w_load;

    assign w_rot_ext   = rotate_right(c_w_max'(up_data), W, 2 ** STAGE);
    assign w_next_data = up_amt[STAGE] ? w_rot_ext[W-1:0] : up_data;

    generate
        if (W < c_w_max) begin : g_unused_pad
            logic w_unused_hi;
            assign w_unused_hi = |w_rot_ext[c_w_max-1:W];
        end
    endgenerate

    // Loading with no upstream word turns this stage into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
        end else if (w_load) begin
            r_valid <= up_valid;
            if (up_valid) begin
                r_data <= w_next_data;
                r_amt  <= up_amt & ~c_stage_bit;
            end
        end
    end

    assign down_valid = r_valid;
    assign down_data  = r_data;
    assign down_amt   = r_amt;

endmodule
`default_nettype wire

// File: rtl/pipe_right_rotator.sv
`default_nettype none
// ============================================================================
// Module   : pipe_right_rotator
// Purpose  : N-stage pipelined barrel rotator (right rotate) with valid/ready
//            handshakes on both sides; one word per cycle, latency N.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid/in_ready     - upstream handshake
//            in_data, in_amt       - word and right-rotate amount
//            out_valid/out_ready   - downstream handshake
//            out_data              - rotated word
//            busy                  - any stage holds a word
// Revision : 1.0 - initial release
// ============================================================================
module pipe_right_rotator
    import pipe_rot_pkg::*;
#(
    parameter  int unsigned N = c_n,
    localparam int unsigned W = 2 ** N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [N-1:0] in_amt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    // Forward path: index k is the input of stage k, index N the final output.
    logic [N:0]   w_valid;
    logic [W-1:0] w_data [0:N];
    logic [N-1:0] w_amt  [0:N];

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_amt[0]   = in_amt;

    // The ready chain is combinational from out_ready back to in_ready, so
    // each stage keeps its ready in its own generate scope rather than in a
    // shared vector.
    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            logic w_up_ready;
            logic w_down_ready;

            if (k == N - 1) begin : g_last
                assign w_down_ready = out_ready;
            end else begin : g_mid
                assign w_down_ready = g_stage[k+1].w_up_ready;
            end

            rot_stage #(
                .N     (N),
                .STAGE (k)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .up_valid   (w_valid[k]),
                .up_ready   (w_up_ready),
                .up_data    (w_data[k]),
                .up_amt     (w_amt[k]),
                .down_valid (w_valid[k+1]),
                .down_ready (w_down_ready),
                .down_data  (w_data[k+1]),
                .down_amt   (w_amt[k+1])
            );
        end
    endgenerate

    assign in_ready  = g_stage[0].w_up_ready;
    assign out_valid = w_valid[N];
    assign out_data  = w_data[N];
    assign busy      = |w_valid[N:1];

    // Every amount bit has been consumed by the time a word leaves.
    logic w_unused_amt;
    assign w_unused_amt = |w_amt[N];

endmodule
`default_nettype wire

// File: doc/pipe_right_rotator.md
PIPE_RIGHT_ROTATOR -- requirements
Module: pipe_right_rotator

Interface
REQ-001 Parameter: N, default 4, log2 of the data width; data width W = 2**N.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  block accepts the upstream word this cycle.
REQ-006 in_data  input  W  word to rotate.
REQ-007 in_amt  input  N  right-rotate amount, 0..W-1.
REQ-008 out_valid  output  1  rotated word present.
REQ-009 out_ready  input  1  downstream accepts the output word this cycle.
REQ-010 out_data  output  W  in_data rotated right by in_amt.
REQ-011 busy  output  1  high while any pipeline stage holds a valid word.

Function
REQ-012 Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-013 Pipeline: N register stages; stage k (0..N-1) rotates right by 2**k when amount bit k is set, else passes the word unchanged.
REQ-014 Each stage carries a valid flag, its data, and the amount bits still to be applied.
REQ-015 Final stage advance condition: out_ready.
REQ-016 Stage k < N-1 advance condition: stage k+1 is empty or advancing.
REQ-017 Stage k load condition: stage k is empty or advancing.
REQ-018 in_ready = stage 0 load condition; the combinational path from out_ready to in_ready is permitted.
REQ-019 A stage that is advancing with no valid word arriving from upstream becomes empty (bubble).
REQ-020 Latency: exactly N cycles from input transfer to out_valid when not stalled; throughput is 1 word/cycle.
REQ-021 out_valid = final stage valid flag; out_data = final stage data.
REQ-022 While out_valid && !out_ready, out_data holds stable.
REQ-023 Words leave in acceptance order, with no loss and no duplication.
REQ-024 in_amt = 0 passes the word unchanged.
REQ-025 in_amt = W-1 equals a left rotation by 1.
REQ-026 Rotation wraps modulo W; bit i of the input appears at bit (i - amt) mod W.
REQ-027 Simultaneous input and output transfers with the pipe full are legal and keep the occupancy constant.
REQ-028 busy = OR of all stage valid flags.

Reset
REQ-029 On rst_n low, all valid flags clear immediately (asynchronously): out_valid=0, busy=0, in_ready=1 after release.
REQ-030 On rst_n low, stage data and amount registers reset to 0.
REQ-031 Reset mid-operation discards in-flight words; no stale word appears after release.

Structure
REQ-032 Package pipe_rot_pkg holds the default N, the derived width W, and a rotate-right-by-constant function used by every stage.
REQ-033 One sub-module, rot_stage (parameter: stage index), implements one register stage.
REQ-034 The top instantiates rot_stage N times via generate and chains their handshakes.

Verification (N=4, W=16)
REQ-035 16'h0001 amt 1 -> 16'h8000, out_valid exactly 4 cycles after acceptance.
REQ-036 16'h1234 amt 4 -> 16'h4123; 16'h1234 amt 0 -> 16'h1234; 16'h8001 amt 15 -> 16'h0003.
REQ-037 Backpressure: 8 back-to-back words with out_ready low for 3 cycles mid-stream.
- Required: all 8 outputs correct, in order.
- Required: in_ready low while the pipe is full and stalled.
- Required: out_data stable during the stall.
REQ-038 Reset: assert rst_n low with 3 words in flight.
- Required: out_valid and busy drop without waiting for a clock edge.
- Required: no output appears after release until new input is accepted.
REQ-039 Randomized: 1000 random words, amounts, and in_valid/out_ready patterns.
- Required: every out_data rotated left by its amount equals its in_data.
- Required: output count equals input count.
